// File: rtl/key_filter_pkg.sv
// Shared types and helpers for the multi-channel key debouncer.
package key_filter_pkg;

    // Per-channel debounce FSM states.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        DOWN       = 2'd2,
        REL_FILT   = 2'd3
    } kf_state_e;

    // Width wide enough to hold the larger of the two cycle counts without wrapping.
    function automatic int cnt_width(input int debounce_cycles, input int long_cycles);
        int max_cycles;
        max_cycles = (debounce_cycles > long_cycles) ? debounce_cycles : long_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: 2-FF synchroniser, debounce FSM, hold timer and registered flags.
module key_filter_ch
    import key_filter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic key,
    output logic key_state,
    output logic press_flag,
    output logic release_flag,
    output logic long_flag
);

    localparam int            CW        = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_MAX  = CW'(LONG_CYCLES);
    localparam logic          IDLE_LVL  = ACTIVE_LOW;

    logic          sync1_q, sync2_q;
    kf_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          long_done_q, long_done_d;
    logic          key_state_q, key_state_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          p;

    // Pressed when the synchronised level differs from the idle level.
    assign p = sync2_q ^ IDLE_LVL;

    // State register.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: any reversal during filtering drops back to the previous stable state.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:       if (p) state_d = PRESS_FILT;
            PRESS_FILT: if (!p) state_d = IDLE;
                        else if (cnt_q == DEB_LAST) state_d = DOWN;
            DOWN:       if (!p) state_d = REL_FILT;
            REL_FILT:   if (p) state_d = DOWN;
                        else if (cnt_q == DEB_LAST) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Datapath and flag logic: filter counter, saturating hold timer, one-shot long press.
    always_comb begin
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        long_done_d = long_done_q;
        key_state_d = key_state_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        case (state_q)
            IDLE: cnt_d = '0;
            PRESS_FILT: begin
                if (p) begin
                    if (cnt_q == DEB_LAST) begin
                        cnt_d       = '0;
                        press_d     = 1'b1;
                        key_state_d = 1'b1;
                        hold_d      = '0;
                        long_done_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DOWN: begin
                cnt_d = '0;
                if (hold_q != HOLD_MAX) hold_d = hold_q + CW'(1);
                if (hold_q == LONG_LAST && !long_done_q) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end
            end
            REL_FILT: begin
                // Hold timer stays frozen here so a bounce back into DOWN resumes it.
                if (!p) begin
                    if (cnt_q == DEB_LAST) begin
                        cnt_d       = '0;
                        release_d   = 1'b1;
                        key_state_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Synchroniser, counters and registered outputs; reset aborts any filtering silently.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q     <= IDLE_LVL;
            sync2_q     <= IDLE_LVL;
            cnt_q       <= '0;
            hold_q      <= '0;
            long_done_q <= 1'b0;
            key_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync1_q     <= key;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            key_state_q <= key_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    assign key_state    = key_state_q;
    assign press_flag   = press_q;
    assign release_flag = release_q;
    assign long_flag    = long_q;

endmodule

// File: rtl/key_filter_multi.sv
// N independent debounced key channels with press/release/long-press flags.
module key_filter_multi #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] press_flag,
    output logic [N_KEYS-1:0] release_flag,
    output logic [N_KEYS-1:0] long_flag
);

    // One fully independent filter per key.
    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_filter_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW != 0)
        ) u_ch (
            .Clk          (Clk),
            .Reset        (Reset),
            .key          (key[g]),
            .key_state    (key_state[g]),
            .press_flag   (press_flag[g]),
            .release_flag (release_flag[g]),
            .long_flag    (long_flag[g])
        );
    end

endmodule

// File: tb/tb_key_filter_multi.sv
// Self-checking bench: directed scenarios plus random key activity against a run-length reference model.
module tb_key_filter_multi;

    localparam int NK   = 4;
    localparam int DEB  = 10;
    localparam int LONG = 50;
    localparam int LAT  = DEB + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key = '1;
    logic [NK-1:0] key_state, press_flag, release_flag, long_flag;

    int n_total = 0;
    int n_bad   = 0;
    bit sb_en   = 1'b0;

    key_filter_multi #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG),
        .ACTIVE_LOW      (1)
    ) dut (
        .Clk          (clk),
        .Reset        (rst),
        .key          (key),
        .key_state    (key_state),
        .press_flag   (press_flag),
        .release_flag (release_flag),
        .long_flag    (long_flag)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once the pressed/released condition has been
    // seen on DEB+1 consecutive synchronised samples. Hold time counts edges spent
    // pressed with no pending release run; long press fires once when it reaches LONG.
    logic [NK-1:0] m_s1 = '1, m_s2 = '1;
    logic [NK-1:0] e_state = '0, e_press = '0, e_rel = '0, e_long = '0;
    int            run  [NK];
    int            hold [NK];
    bit            ldone[NK];

    always @(posedge clk) begin
        for (int c = 0; c < NK; c++) begin
            bit pr;
            e_press[c] = 1'b0;
            e_rel[c]   = 1'b0;
            e_long[c]  = 1'b0;
            if (rst) begin
                e_state[c] = 1'b0;
                run[c]     = 0;
                hold[c]    = 0;
                ldone[c]   = 1'b0;
            end else begin
                pr = ~m_s2[c];
                if (e_state[c] && run[c] == 0) begin
                    if (hold[c] < LONG) hold[c]++;
                    if (hold[c] == LONG && !ldone[c]) begin
                        e_long[c] = 1'b1;
                        ldone[c]  = 1'b1;
                    end
                end
                if (pr != e_state[c]) begin
                    run[c]++;
                    if (run[c] == DEB + 1) begin
                        run[c]     = 0;
                        e_state[c] = pr;
                        if (pr) begin
                            e_press[c] = 1'b1;
                            hold[c]    = 0;
                            ldone[c]   = 1'b0;
                        end else begin
                            e_rel[c] = 1'b1;
                        end
                    end
                end else begin
                    run[c] = 0;
                end
            end
        end
        if (rst) begin
            m_s1 = '1;
            m_s2 = '1;
        end else begin
            m_s2 = m_s1;
            m_s1 = key;
        end
    end

    // Cycle-by-cycle scoreboard on the falling edge.
    always @(negedge clk) begin
        if (sb_en) begin
            check("sb_key_state", 32'(key_state), 32'(e_state));
            check("sb_press", 32'(press_flag), 32'(e_press));
            check("sb_release", 32'(release_flag), 32'(e_rel));
            check("sb_long", 32'(long_flag), 32'(e_long));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Edges until the selected flag (0 press, 1 release, 2 long) appears on ch; -1 on timeout.
    task automatic wait_flag(input int ch, input int kind, input int limit, output int edges);
        bit found = 1'b0;
        edges = 0;
        while (!found && edges < limit) begin
            @(negedge clk);
            edges++;
            case (kind)
                0:       found = press_flag[ch];
                1:       found = release_flag[ch];
                default: found = long_flag[ch];
            endcase
        end
        if (!found) edges = -1;
    endtask

    // Count flag pulses on the masked channels over n cycles.
    task automatic watch(input int n, input logic [NK-1:0] mask, output int np, output int nr, output int nl);
        np = 0; nr = 0; nl = 0;
        repeat (n) begin
            @(negedge clk);
            if (|(press_flag & mask))   np++;
            if (|(release_flag & mask)) nr++;
            if (|(long_flag & mask))    nl++;
        end
    endtask

    initial begin
        int e, np, nr, nl, tp, tr, tl;

        // 1: reset with keys idle, then a quiet period.
        @(negedge clk);
        sb_en = 1'b1;
        tick(4);
        check("rst_state", 32'(key_state), 32'h0);
        check("rst_press", 32'(press_flag), 32'h0);
        check("rst_release", 32'(release_flag), 32'h0);
        check("rst_long", 32'(long_flag), 32'h0);
        rst = 1'b0;
        watch(100, '1, np, nr, nl);
        check("idle_flags", 32'(np + nr + nl), 32'h0);

        // 2: clean press and release on key 0.
        key[0] = 1'b0;
        wait_flag(0, 0, 40, e);
        check("t2_press_lat", 32'(e), 32'(LAT));
        check("t2_state_hi", 32'(key_state[0]), 32'h1);
        @(negedge clk);
        check("t2_press_width", 32'(press_flag[0]), 32'h0);
        tick(20);
        key[0] = 1'b1;
        wait_flag(0, 1, 40, e);
        check("t2_rel_lat", 32'(e), 32'(LAT));
        check("t2_state_lo", 32'(key_state[0]), 32'h0);
        tick(20);

        // 3: bouncing press and release on key 1.
        for (int i = 0; i < 6; i++) begin
            key[1] = ~key[1];
            watch(4, 4'b0010, np, nr, nl);
            check("t3_bounce_press", 32'(np + nr + nl), 32'h0);
        end
        key[1] = 1'b0;
        wait_flag(1, 0, 40, e);
        check("t3_press_lat", 32'(e), 32'(LAT));
        tick(20);
        tp = 0; tr = 0;
        for (int i = 0; i < 6; i++) begin
            key[1] = ~key[1];
            watch(4, 4'b0010, np, nr, nl);
            tp += np; tr += nr;
        end
        key[1] = 1'b1;
        watch(40, 4'b0010, np, nr, nl);
        check("t3_rel_count", 32'(tr + nr), 32'h1);
        check("t3_no_press", 32'(tp + np), 32'h0);

        // 4: long press on key 2, then a short press with no long flag.
        key[2] = 1'b0;
        wait_flag(2, 0, 40, e);
        check("t4_press_lat", 32'(e), 32'(LAT));
        wait_flag(2, 2, 80, e);
        check("t4_long_lat", 32'(e), 32'(LONG));
        watch(150, 4'b0100, np, nr, nl);
        check("t4_long_once", 32'(nl), 32'h0);
        key[2] = 1'b1;
        wait_flag(2, 1, 40, e);
        check("t4_rel_lat", 32'(e), 32'(LAT));
        tick(20);
        key[2] = 1'b0;
        watch(30, 4'b0100, tp, tr, tl);
        key[2] = 1'b1;
        watch(100, 4'b0100, np, nr, nl);
        check("t4_short_press", 32'(tp + np), 32'h1);
        check("t4_short_rel", 32'(tr + nr), 32'h1);
        check("t4_short_nolong", 32'(tl + nl), 32'h0);

        // 5: simultaneous press on keys 0 and 3.
        key = 4'b0110;
        wait_flag(0, 0, 40, e);
        check("t5_press_lat", 32'(e), 32'(LAT));
        check("t5_press_vec", 32'(press_flag), 32'h9);
        check("t5_state_vec", 32'(key_state), 32'h9);
        key = 4'hF;
        wait_flag(3, 1, 40, e);
        check("t5_rel_lat", 32'(e), 32'(LAT));
        check("t5_rel_vec", 32'(release_flag), 32'h9);
        tick(20);

        // 6: reset during press filtering, then during a held key.
        key[0] = 1'b0;
        tick(8);
        rst = 1'b1;
        key = 4'hF;
        watch(5, '1, np, nr, nl);
        rst = 1'b0;
        check("t6_state_pf", 32'(key_state), 32'h0);
        watch(30, '1, tp, tr, tl);
        check("t6_flags_pf", 32'(np + nr + nl + tp + tr + tl), 32'h0);
        key[0] = 1'b0;
        wait_flag(0, 0, 40, e);
        check("t6_repress_lat", 32'(e), 32'(LAT));
        tick(20);
        rst = 1'b1;
        key[0] = 1'b1;
        watch(5, '1, np, nr, nl);
        rst = 1'b0;
        check("t6_state_down", 32'(key_state), 32'h0);
        watch(30, '1, tp, tr, tl);
        check("t6_flags_down", 32'(np + nr + nl + tp + tr + tl), 32'h0);

        // Random activity: toggles with random dwell times, checked by the scoreboard.
        for (int i = 0; i < 80; i++) begin
            int ch;
            ch = int'($urandom_range(0, NK - 1));
            key[ch] = ~key[ch];
            tick(int'($urandom_range(1, 75)));
        end
        key = 4'hF;
        tick(80);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #2ms;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
